flowcontrol: RTL and testbench

FLOWCONTROL -- requirements
Module: flowcontrol

---
 rtl/flowcontrol.sv | 95 +++++++++
 tb/tb_flowcontrol.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/flowcontrol.sv
// -----------------------------------------------------------------------------
// flowcontrol
//
// Purpose:
//   Flow control for the five output directions of a router: North, East,
//   West, South and Local. Each direction is a separate channel with no link
//   to the others. An input FIFO may send toward direction X only when it
//   requests X (Xport) and the output FIFO of X can accept data (Xready_in).
//   No arbitration is done here. Each grant is decided separately.
//
// Configuration:
//   FLOWCONTROL_BYPASS_EN  undefined (default): each Xready_out comes from a
//                          register. It shows the inputs sampled at the
//                          previous rising clk edge, so latency is one cycle.
//                          While rst is high at an edge, all grants clear.
//                          defined: each Xready_out is combinational and
//                          equals ~rst & Xport & Xready_in. This mode has
//                          zero latency and no registers.
//
// Ports:
//   rst         in   synchronous active-high reset, sampled on rising clk
//   Xport       in   input FIFO requests a transfer toward direction X
//   Xready_in   in   output FIFO of direction X can accept data
//   Xready_out  out  input FIFO may send toward direction X
//   clk         in   rising-edge clock for all state
//   (X is one of N, E, W, S, L.)
// -----------------------------------------------------------------------------
module flowcontrol (
    input  logic rst,
    input  logic Nport,
    input  logic Eport,
    input  logic Wport,
    input  logic Sport,
    input  logic Lport,
    input  logic Lready_in,
    input  logic Nready_in,
    input  logic Eready_in,
    input  logic Wready_in,
    input  logic Sready_in,
    output logic Lready_out,
    output logic Nready_out,
    output logic Eready_out,
    output logic Wready_out,
    output logic Sready_out,
    input  logic clk
);

    localparam int NUM_DIRS = 5;

    // Bit positions of the packed direction vectors below.
    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_W = 2;
    localparam int DIR_S = 3;
    localparam int DIR_L = 4;

    logic [NUM_DIRS-1:0] port_req;   // requests, one bit per direction
    logic [NUM_DIRS-1:0] out_ready;  // downstream ready, one bit per direction
    logic [NUM_DIRS-1:0] grant;      // permission to send, one bit per direction

    assign port_req  = {Lport, Sport, Wport, Eport, Nport};
    assign out_ready = {Lready_in, Sready_in, Wready_in, Eready_in, Nready_in};

`ifdef FLOWCONTROL_BYPASS_EN
    // Combinational path. The clock is not needed in this mode.
    logic unused_clk;
    assign unused_clk = clk;

    assign grant = {NUM_DIRS{~rst}} & port_req & out_ready;
`else
    logic [NUM_DIRS-1:0] grant_q;

    // Each bit is a separate flop on its own request and ready input.
    // Reset has priority, so a grant that is active is cleared at the next edge.
    always_ff @(posedge clk) begin
        // NOTE: use non-blocking assignments for state so that every flop
        // samples values from before the edge. This way, evaluation order
        // does not affect the result.
        if (rst) begin
            grant_q <= '0;
        end else begin
            grant_q <= port_req & out_ready;
        end
    end

    assign grant = grant_q;
`endif

    assign Nready_out = grant[DIR_N];
    assign Eready_out = grant[DIR_E];
    assign Wready_out = grant[DIR_W];
    assign Sready_out = grant[DIR_S];
    assign Lready_out = grant[DIR_L];

endmodule

// File: tb/tb_flowcontrol.sv
// -----------------------------------------------------------------------------
// tb_flowcontrol
//
// Directed self-checking bench for flowcontrol. Inputs change on the falling
// edge. In registered mode, outputs are sampled 1 ns after the next rising
// edge. In bypass mode (FLOWCONTROL_BYPASS_EN), they are sampled 1 ns after
// the inputs change. Vector bit order is N=0, E=1, W=2, S=3, L=4.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flowcontrol;

    logic       clk;
    logic       rst;
    logic [4:0] port_v;
    logic [4:0] rdy_v;
    logic [4:0] out_v;

    int errors;
    int checks;

    wire Nready_out, Eready_out, Wready_out, Sready_out, Lready_out;
    assign out_v = {Lready_out, Sready_out, Wready_out, Eready_out, Nready_out};

    flowcontrol dut (
        .rst        (rst),
        .Nport      (port_v[0]),
        .Eport      (port_v[1]),
        .Wport      (port_v[2]),
        .Sport      (port_v[3]),
        .Lport      (port_v[4]),
        .Lready_in  (rdy_v[4]),
        .Nready_in  (rdy_v[0]),
        .Eready_in  (rdy_v[1]),
        .Wready_in  (rdy_v[2]),
        .Sready_in  (rdy_v[3]),
        .Lready_out (Lready_out),
        .Nready_out (Nready_out),
        .Eready_out (Eready_out),
        .Wready_out (Wready_out),
        .Sready_out (Sready_out),
        .clk        (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply a new input set on the falling edge.
    task automatic drive(input logic r, input logic [4:0] p, input logic [4:0] d);
        @(negedge clk);
        rst    = r;
        port_v = p;
        rdy_v  = d;
    endtask

    // Wait until the outputs show the inputs just driven.
    task automatic settle();
`ifdef FLOWCONTROL_BYPASS_EN
        #1;
`else
        @(posedge clk);
        #1;
`endif
    endtask

    // Hold reset for 4 cycles with all inputs high, then release it.
    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'h1f, 5'h1f);
            settle();
            checks++;
            if (out_v !== 5'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, out_v, 5'h00);
            end
        end
        drive(1'b0, 5'h1f, 5'h1f);
`ifndef FLOWCONTROL_BYPASS_EN
        #1;
        checks++;
        if (out_v !== 5'h00) begin
            errors++;
            $display("FAIL reset_release_pre_edge: got %b expected %b", out_v, 5'h00);
        end
`endif
        settle();
        checks++;
        if (out_v !== 5'h1f) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", out_v, 5'h1f);
        end
    endtask

    // Step {port, ready_in} of one direction through 00, 01, 10, 11.
    // A reset comes first, so outputs start at zero.
    task automatic test_walk(input int d, input string name);
        logic [4:0] one_hot;
        logic [4:0] exp;
        one_hot = 5'b00001 << d;
        drive(1'b1, 5'h00, 5'h00);
        settle();
        checks++;
        if (out_v !== 5'h00) begin
            errors++;
            $display("FAIL walk_%s_reset: got %b expected %b", name, out_v, 5'h00);
        end
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, (s >= 2) ? one_hot : 5'h00, (s % 2 == 1) ? one_hot : 5'h00);
            exp = (s == 3) ? one_hot : 5'h00;
`ifndef FLOWCONTROL_BYPASS_EN
            if (s == 3) begin
                // Before the edge, the output must still show the step-10 result.
                #1;
                checks++;
                if (out_v !== 5'h00) begin
                    errors++;
                    $display("FAIL walk_%s_latency: got %b expected %b", name, out_v, 5'h00);
                end
            end
`endif
            settle();
            checks++;
            if (out_v !== exp) begin
                errors++;
                $display("FAIL walk_%s_step%0d%0d: got %b expected %b",
                         name, s / 2, s % 2, out_v, exp);
            end
        end
    endtask

    // All five directions granted, then Wready_in drops. Only W may fall.
    task automatic test_drop_ready();
        drive(1'b0, 5'h1f, 5'h1f);
        settle();
        checks++;
        if (out_v !== 5'h1f) begin
            errors++;
            $display("FAIL drop_all_granted: got %b expected %b", out_v, 5'h1f);
        end
        drive(1'b0, 5'h1f, 5'b11011);
        settle();
        checks++;
        if (out_v !== 5'b11011) begin
            errors++;
            $display("FAIL drop_w_ready: got %b expected %b", out_v, 5'b11011);
        end
        drive(1'b0, 5'h1f, 5'h1f);
        settle();
        checks++;
        if (out_v !== 5'h1f) begin
            errors++;
            $display("FAIL drop_w_recover: got %b expected %b", out_v, 5'h1f);
        end
    endtask

    // Reset while all grants are active, then release.
    task automatic test_reset_mid();
        drive(1'b1, 5'h1f, 5'h1f);
        settle();
        checks++;
        if (out_v !== 5'h00) begin
            errors++;
            $display("FAIL reset_mid: got %b expected %b", out_v, 5'h00);
        end
        drive(1'b0, 5'h1f, 5'h1f);
        settle();
        checks++;
        if (out_v !== 5'h1f) begin
            errors++;
            $display("FAIL reset_mid_resume: got %b expected %b", out_v, 5'h1f);
        end
    endtask

    // Mixed patterns over several directions. Each bit is port & ready.
    task automatic test_mixed();
        logic [4:0] p_tab [4];
        logic [4:0] d_tab [4];
        logic [4:0] e_tab [4];
        p_tab[0] = 5'b10110; d_tab[0] = 5'b11100; e_tab[0] = 5'b10100;
        p_tab[1] = 5'b01001; d_tab[1] = 5'b01011; e_tab[1] = 5'b01001;
        p_tab[2] = 5'b11111; d_tab[2] = 5'b00000; e_tab[2] = 5'b00000;
        p_tab[3] = 5'b00101; d_tab[3] = 5'b10111; e_tab[3] = 5'b00101;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, p_tab[i], d_tab[i]);
            settle();
            checks++;
            if (out_v !== e_tab[i]) begin
                errors++;
                $display("FAIL mixed[%0d]: got %b expected %b", i, out_v, e_tab[i]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        port_v = 5'h00;
        rdy_v  = 5'h00;

        test_reset();
        test_walk(0, "N");
        test_walk(1, "E");
        test_walk(2, "W");
        test_walk(3, "S");
        test_walk(4, "L");
        test_drop_ready();
        test_reset_mid();
        test_mixed();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
